// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - MAR/MDR memory responder with programmable wait states
// Serializes one RAM access per strobe assertion and reports completion with a ready pulse.
module mem_responder #(
   parameter int DEPTH       = 512,
   parameter int ADDR_W      = 9,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clock,
   input  logic        clr,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] Mdatain,
   output logic        ready,
   output logic        err,
   output logic        busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_HOLD} state_t;

   state_t        r_state;
   logic [3:0]    r_cnt;
   logic          r_op_wr;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [31:0]   r_mdata;
   logic          r_ready;
   logic          r_err;
   logic [31:0]   r_mem [DEPTH];

   logic              w_last;
   logic              w_in_range;
   logic              w_we;
   logic [ADDR_W-1:0] w_idx;

   assign w_last     = (r_cnt == 4'(WAIT_CYCLES - 1));
   assign w_in_range = (r_addr < 32'(DEPTH));
   assign w_idx      = r_addr[ADDR_W-1:0];
   // clr wins over a write that would land on the same edge
   assign w_we       = (r_state == ST_WAIT) && w_last && r_op_wr && w_in_range && !clr;

   always_ff @(posedge clock) begin
      if (w_we) begin
         r_mem[w_idx] <= r_wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (clr) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_op_wr <= 1'b0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_mdata <= 32'd0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (read ^ write) begin
                  r_op_wr <= write;
                  r_addr  <= addr;
                  r_wdata <= wdata;
                  r_cnt   <= 4'd0;
                  r_state <= ST_WAIT;
               end else if (read && write) begin
                  r_err   <= 1'b1;
                  r_state <= ST_HOLD;
               end
            end
            ST_WAIT: begin
               if (w_last) begin
                  r_ready <= 1'b1;
                  r_state <= ST_ACK;
                  if (!w_in_range) begin
                     r_err <= 1'b1;
                     if (!r_op_wr) begin
                        r_mdata <= 32'd0;
                     end
                  end else if (!r_op_wr) begin
                     r_mdata <= r_mem[w_idx];
                  end
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            ST_ACK: begin
               r_state <= (read || write) ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
               if (!read && !write) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign Mdatain = r_mdata;
   assign ready   = r_ready;
   assign err     = r_err;
   assign busy    = (r_state != ST_IDLE);

endmodule
